// File: rtl/car_lane.sv
// car_lane: one Frogger traffic lane; a rotating car pattern with its own prescaler,
// pause, direction control and a latched game-over on collision.
module car_lane #(
   parameter int               WIDTH       = 16,
   parameter logic [WIDTH-1:0] PATTERN     = 16'b0011000110001100,
   parameter int               START_SHIFT = 0,
   parameter bit               DIR_LEFT    = 0,
   parameter int               TICK_WIDTH  = 9
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             hit,
   input  logic [1:0]       speed,
   output logic [WIDTH-1:0] pixels,
   output logic             step,
   output logic             game_over
);
   typedef enum logic [1:0] {RUN, PAUSE, OVER} state_t;

   function automatic logic [WIDTH-1:0] rot1(input logic [WIDTH-1:0] p);
      return DIR_LEFT ? {p[WIDTH-2:0], p[WIDTH-1]} : {p[0], p[WIDTH-1:1]};
   endfunction

   function automatic logic [WIDTH-1:0] rotn(input int n);
      logic [WIDTH-1:0] p;
      p = PATTERN;
      for (int i = 0; i < n; i++) p = rot1(p);
      return p;
   endfunction

   localparam logic [WIDTH-1:0] INIT = rotn(START_SHIFT);

   state_t                state_q;
   logic [TICK_WIDTH-1:0] cnt_q;
   logic [2:0]            sub_q;
   logic [WIDTH-1:0]      pix_q, pix_d;
   logic                  step_q;
   logic                  run, base_tick, move;
   logic [2:0]            mask;

   assign run       = (state_q != OVER) && enable;
   assign base_tick = run && (&cnt_q);
   assign mask      = 3'b111 >> speed;
   assign move      = base_tick && ((sub_q & mask) == mask);
   assign pix_d     = rot1(pix_q);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= RUN;
         cnt_q   <= '0;
         sub_q   <= '0;
         pix_q   <= INIT;
         step_q  <= 1'b0;
      end else if (state_q == OVER) begin
         step_q <= 1'b0;
      end else if (hit) begin
         // collision beats a coincident move
         state_q <= OVER;
         pix_q   <= '0;
         step_q  <= 1'b0;
      end else begin
         state_q <= enable ? RUN : PAUSE;
         if (run) cnt_q <= cnt_q + 1'b1;
         if (base_tick) sub_q <= sub_q + 3'd1;
         if (move) pix_q <= pix_d;
         step_q <= move;
      end
   end

   assign pixels    = pix_q;
   assign step      = step_q;
   assign game_over = (state_q == OVER);
endmodule

// File: doc/car_lane.md
Name: car_lane

Overview:
- Parametrised moving-car row for the Frogger LED matrix: a repeating car pattern of WIDTH pixels rotates across one lane at a selectable speed.
- Includes its own prescaler, a pause input, direction control, and a latched game-over state on collision.
- One instance per traffic lane. The collision logic drives hit; the display mux consumes pixels.

Parameters:
- WIDTH, 16: lane width in pixels, which is also the pattern width.
- PATTERN, 16'b0011000110001100: car pattern loaded at reset. Bit i lights column i.
- START_SHIFT, 0: number of rotations (in the DIR_LEFT direction) applied to PATTERN at reset. Legal range 0..WIDTH-1.
- DIR_LEFT, 0: rotation direction. 0 rotates toward the LSB (bit 0 takes bit 1). 1 rotates toward the MSB.
- TICK_WIDTH, 9: width of the base prescaler. A base tick occurs every 2^TICK_WIDTH enabled cycles.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high.
- enable, input, 1: 1 means the lane runs; 0 means paused.
- hit, input, 1: collision pulse or level from the frog logic.
- speed, input, 2: 0 is slowest, 3 is fastest.
- pixels, output, WIDTH: current lane image (registered).
- step, output, 1: one-cycle pulse, high in the cycle pixels shows a new rotation.
- game_over, output, 1: high while latched in the OVER state (registered).

Behaviour:
- States:
  - RUN: enable=1, not over.
  - PAUSE: enable=0, not over.
  - OVER: entered on hit.
- Reset values:
  - state RUN.
  - prescaler cnt = 0, sub-counter sub = 0.
  - pixels = PATTERN rotated START_SHIFT positions in the DIR_LEFT direction.
  - step = 0, game_over = 0.
- Base tick: cnt (TICK_WIDTH bits) increments each cycle in RUN and holds in PAUSE/OVER. base_tick is combinational: cnt == all-ones while in RUN. cnt then wraps to 0.
- Speed divider: sub (3 bits) increments on each base_tick and wraps mod 8.
  - mask = 3'b111 >> speed.
  - Move condition: base_tick AND (sub & mask) == mask.
  - Resulting rate: speed 3 moves every base tick, 2 every 2nd, 1 every 4th, 0 every 8th.
- Move: at the clock edge where the move condition is true, pixels rotates one position in the DIR_LEFT direction and step is registered to 1. Otherwise step = 0. Latency is 1 cycle from the move condition to the new pixels and step.
- Speed change: applies from the next base tick. sub is not cleared. No glitch or double step.
- PAUSE: cnt, sub and pixels hold, and step = 0. Returning to RUN resumes exactly where it stopped, with no lost or extra tick.
- hit in RUN or PAUSE: at the next edge, state becomes OVER, game_over = 1, pixels = 0 and step = 0.
- hit priority: hit in the same cycle as a move condition wins. No rotation occurs and step stays 0.
- OVER: absorbing state.
  - pixels = 0, game_over = 1, step = 0.
  - cnt and sub hold.
  - hit and enable are ignored.
  - Exit only via reset.
- Reset mid-operation, including from OVER: restores all reset values at the next edge, regardless of hit or enable in that cycle.
- Rotation wrap: the bit shifted out re-enters at the opposite end. After WIDTH moves, pixels equals its starting value.
- No combinational path from inputs to outputs.

Test Plan:
All scenarios use TICK_WIDTH=2, WIDTH=16 and the default PATTERN.
- Reset image: reset 1 cycle, then enable=1, speed=3 -> pixels=0011000110001100 and game_over=0. The first step pulse comes 4 cycles after reset release, with pixels=0001100011000110 in that cycle.
- Speed and wrap: speed=3 for 64 cycles -> exactly 16 step pulses, spaced 4 cycles apart, and pixels back at 0011000110001100. Repeat with speed=0 -> steps spaced 32 cycles apart.
- Pause: drop enable for 10 cycles mid-interval -> no step and pixels frozen. On re-enable, the next step arrives after the remaining count, with total enabled cycles between steps still 4.
- Direction and offset: DIR_LEFT=1, START_SHIFT=1 -> reset pixels=0110001100011000. The first step gives 1100011000110000.
- Hit and priority: pulse hit in the same cycle as a move condition -> next cycle pixels=0, game_over=1, step=0. Afterwards, hit and enable toggling cause no change for 100 cycles.
- Recovery: reset asserted while OVER -> next cycle pixels=0011000110001100, game_over=0, and normal stepping resumes.
